// File: rtl/mcmc_sample_packer.sv
// Packs pairs of 32-bit samples into 64-bit BRAM words, written sequentially from BASE_ADDR.
// Optional build macro PACKER_CHECKSUM_EN enables the running sample checksum output.
module mcmc_sample_packer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [31:0] DEPTH_WORDS = 32'd1024,
    parameter logic [31:0] ADDR_STEP   = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        flush,
    output logic [31:0] bram_addr,
    output logic [63:0] bram_din,
    output logic        bram_en,
    output logic [7:0]  bram_we,
    output logic        busy,
    output logic        finish,
    output logic [31:0] word_count,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {S_IDLE, S_EMPTY, S_HALF, S_WRITE, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_lo;
    logic [31:0] r_addr, r_next_addr, r_word_count;
    logic [63:0] r_din;
    logic        r_en, r_flush_lat, r_finish;
    logic [7:0]  r_we;
    logic        w_xfer, w_flush, w_last, w_arm;

    assign s_ready    = (r_state == S_EMPTY) || (r_state == S_HALF);
    assign busy       = (r_state == S_EMPTY) || (r_state == S_HALF) || (r_state == S_WRITE);
    assign w_xfer     = s_valid && s_ready;
    assign w_flush    = flush || r_flush_lat;
    // Region full and latched flush both end the run after the current write.
    assign w_last     = ((r_word_count + 32'd1) == DEPTH_WORDS) || r_flush_lat;
    assign w_arm      = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign bram_addr  = r_addr;
    assign bram_din   = r_din;
    assign bram_en    = r_en;
    assign bram_we    = r_we;
    assign finish     = r_finish;
    assign word_count = r_word_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_EMPTY;
            S_EMPTY: begin
                if (w_xfer)       w_next = S_HALF;
                else if (w_flush) w_next = S_DONE;
            end
            S_HALF:  if (w_xfer || w_flush) w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_DONE : S_EMPTY;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo         <= '0;
            r_din        <= '0;
            r_addr       <= BASE_ADDR;
            r_next_addr  <= BASE_ADDR;
            r_word_count <= '0;
            r_en         <= 1'b0;
            r_we         <= '0;
            r_flush_lat  <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            r_en <= 1'b0;
            r_we <= '0;
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_word_count <= '0;
                    r_finish     <= 1'b0;
                    r_addr       <= BASE_ADDR;
                    r_next_addr  <= BASE_ADDR;
                    r_flush_lat  <= 1'b0;
                end
                S_EMPTY: begin
                    if (w_xfer) begin
                        r_lo <= s_data;
                        if (flush) r_flush_lat <= 1'b1;
                    end else if (w_flush) begin
                        r_finish <= 1'b1;
                    end
                end
                S_HALF: begin
                    // Write outputs are registered on entry so they line up with the WRITE cycle.
                    if (w_xfer) begin
                        r_en   <= 1'b1;
                        r_we   <= 8'hFF;
                        r_din  <= {s_data, r_lo};
                        r_addr <= r_next_addr;
                        if (flush) r_flush_lat <= 1'b1;
                    end else if (w_flush) begin
                        r_en        <= 1'b1;
                        r_we        <= 8'h0F;
                        r_din       <= {32'h0, r_lo};
                        r_addr      <= r_next_addr;
                        r_flush_lat <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_word_count <= r_word_count + 32'd1;
                    r_next_addr  <= r_next_addr + ADDR_STEP;
                    if (w_last) r_finish <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PACKER_CHECKSUM_EN
    logic [31:0] r_checksum;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_checksum <= '0;
        else if (w_arm)  r_checksum <= '0;
        else if (w_xfer) r_checksum <= r_checksum + s_data;
    end
    assign checksum = r_checksum;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mcmc_sample_packer.sv
// Scoreboarded random/directed bench for mcmc_sample_packer across three parameterisations.
module tb_mcmc_sample_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a   [3];
    logic [31:0] s_data_a  [3];
    logic        s_valid_a [3];
    logic        flush_a   [3];
    logic        s_ready_a [3];
    logic [31:0] bram_addr_a [3];
    logic [63:0] bram_din_a  [3];
    logic        bram_en_a   [3];
    logic [7:0]  bram_we_a   [3];
    logic        busy_a      [3];
    logic        finish_a    [3];
    logic [31:0] word_count_a[3];
    logic [31:0] checksum_a  [3];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] din;
        logic [7:0]  we;
    } wr_t;

    wr_t expq [3][$];
    int  n_checks = 0;
    int  n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h100 : 32'h0;
    endfunction
    function automatic logic [31:0] step_of(input int k);
        return (k == 2) ? 32'd8 : 32'd1;
    endfunction
    function automatic int depth_of(input int k);
        return (k == 1) ? 2 : 1024;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mcmc_sample_packer #(
            .BASE_ADDR  (g == 2 ? 32'h100 : 32'h0),
            .DEPTH_WORDS(g == 1 ? 32'd2 : 32'd1024),
            .ADDR_STEP  (g == 2 ? 32'd8 : 32'd1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_a[g]),
            .s_data    (s_data_a[g]),
            .s_valid   (s_valid_a[g]),
            .s_ready   (s_ready_a[g]),
            .flush     (flush_a[g]),
            .bram_addr (bram_addr_a[g]),
            .bram_din  (bram_din_a[g]),
            .bram_en   (bram_en_a[g]),
            .bram_we   (bram_we_a[g]),
            .busy      (busy_a[g]),
            .finish    (finish_a[g]),
            .word_count(word_count_a[g]),
            .checksum  (checksum_a[g])
        );

        // Monitor: every BRAM write must match the next predicted write.
        always @(negedge clk) begin
            if (!rst && bram_en_a[g]) begin
                n_checks++;
                if (expq[g].size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write[%0d] addr=%h din=%h we=%h", g,
                             bram_addr_a[g], bram_din_a[g], bram_we_a[g]);
                end else begin
                    wr_t e;
                    e = expq[g].pop_front();
                    if (bram_addr_a[g] !== e.addr || bram_din_a[g] !== e.din || bram_we_a[g] !== e.we) begin
                        n_errors++;
                        $display("FAIL write[%0d] act=%h/%h/%h exp=%h/%h/%h", g, bram_addr_a[g],
                                 bram_din_a[g], bram_we_a[g], e.addr, e.din, e.we);
                    end
                end
            end
        end
    end

    // Reference: pairs packed low-first, capped at the region size, odd leftover written half.
    task automatic model(input int k, input int n, input logic [31:0] d[16],
                         output int acc, output int words, output logic [31:0] sum);
        wr_t w;
        acc = (n < 2 * depth_of(k)) ? n : 2 * depth_of(k);
        words = (acc + 1) / 2;
        sum = 32'h0;
        for (int i = 0; i < acc; i++) sum = sum + d[i];
        for (int i = 0; i < acc / 2; i++) begin
            w.addr = base_of(k) + i * step_of(k);
            w.din  = {d[2*i+1], d[2*i]};
            w.we   = 8'hFF;
            expq[k].push_back(w);
        end
        if (acc % 2 == 1) begin
            w.addr = base_of(k) + (acc / 2) * step_of(k);
            w.din  = {32'h0, d[acc-1]};
            w.we   = 8'h0F;
            expq[k].push_back(w);
        end
    endtask

    task automatic feed(input int k, input logic [31:0] v, input bit fl, output bit ok, output bit stopped);
        int t = 0;
        ok = 0;
        stopped = 0;
        s_data_a[k]  = v;
        s_valid_a[k] = 1'b1;
        flush_a[k]   = fl;
        while (1) begin
            if (s_ready_a[k]) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            if (finish_a[k]) begin
                stopped = 1;
                break;
            end
            if (t == 50) begin
                chk("ready_timeout", 64'(t), 64'd0);
                stopped = 1;
                break;
            end
            t++;
            @(posedge clk); #1;
        end
        s_valid_a[k] = 1'b0;
        flush_a[k]   = 1'b0;
    endtask

    task automatic do_run(input int k, input int n, input bit seq, input bit flush_last,
                          input int gapmode, input bit mid_chk);
        logic [31:0] d[16];
        int acc, words, got, t;
        logic [31:0] sum;
        bit ok, stopped;
        for (int i = 0; i < 16; i++) d[i] = seq ? 32'(i + 1) : $urandom;
        model(k, n, d, acc, words, sum);
        start_a[k] = 1'b1;
        @(posedge clk); #1;
        start_a[k] = 1'b0;
        got = 0;
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < gaps; j++) begin @(posedge clk); #1; end
            feed(k, d[i], flush_last && (i == n - 1), ok, stopped);
            if (ok) got++;
            if (stopped) break;
        end
        chk($sformatf("accepted[%0d]", k), 64'(got), 64'(acc));
        if (n > 0) begin @(posedge clk); #1; end
        if (mid_chk) begin
            chk("mid_word_count", 64'(word_count_a[k]), 64'd2);
            chk("mid_busy", 64'(busy_a[k]), 64'd1);
        end
        flush_a[k] = 1'b1;
        t = 0;
        while (!finish_a[k] && t < 20) begin @(posedge clk); #1; t++; end
        flush_a[k] = 1'b0;
        if (n == 0) chk("flush_empty_latency", 64'(t), 64'd1);
        @(posedge clk); #1;
        chk($sformatf("finish[%0d]", k), 64'(finish_a[k]), 64'd1);
        chk($sformatf("busy_done[%0d]", k), 64'(busy_a[k]), 64'd0);
        chk($sformatf("ready_done[%0d]", k), 64'(s_ready_a[k]), 64'd0);
        chk($sformatf("word_count[%0d]", k), 64'(word_count_a[k]), 64'(words));
`ifdef PACKER_CHECKSUM_EN
        chk($sformatf("checksum[%0d]", k), 64'(checksum_a[k]), 64'(sum));
`else
        chk($sformatf("checksum[%0d]", k), 64'(checksum_a[k]), 64'd0);
`endif
        chk($sformatf("writes_drained[%0d]", k), 64'(expq[k].size()), 64'd0);
    endtask

    initial begin
        bit ok, stopped;
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 0; s_data_a[k] = 0; s_valid_a[k] = 0; flush_a[k] = 0;
        end
        #80;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_addr[%0d]", k), 64'(bram_addr_a[k]), 64'(base_of(k)));
            chk($sformatf("rst_en_ready[%0d]", k), {62'd0, bram_en_a[k], s_ready_a[k]}, 64'd0);
            chk($sformatf("rst_finish_busy[%0d]", k), {62'd0, finish_a[k], busy_a[k]}, 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_run(0, 4, 1, 0, 0, 1);   // two full words, still busy before flush
        do_run(1, 5, 1, 0, 0, 0);   // region full after two words, 5th refused
        do_run(0, 3, 1, 0, 0, 0);   // trailing half word on flush
        do_run(0, 0, 1, 0, 0, 0);   // flush straight from EMPTY
        do_run(2, 6, 1, 0, 1, 0);   // byte addressing, gapped input
        for (int r = 0; r < 12; r++)
            do_run(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), 0,
                   1'($urandom_range(0, 1)), 2, 0);

        // Reset in the middle of a write, then a fresh run from BASE_ADDR.
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        begin
            wr_t w;
            w.addr = 32'h0; w.din = 64'h00000002_00000001; w.we = 8'hFF;
            expq[0].push_back(w);
        end
        feed(0, 32'd1, 0, ok, stopped);
        feed(0, 32'd2, 0, ok, stopped);
        chk("write_before_rst", 64'(bram_en_a[0]), 64'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_en_we", {55'd0, bram_en_a[0], bram_we_a[0]}, 64'd0);
        chk("rst_din", bram_din_a[0], 64'd0);
        chk("rst_wc_cs", {word_count_a[0], checksum_a[0]}, 64'd0);
        chk("rst_busy_finish", {62'd0, busy_a[0], finish_a[0]}, 64'd0);
        chk("rst_addr_again", 64'(bram_addr_a[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_run(0, 4, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
